// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: four-master round-robin bus arbiter with active-low request/grant and a grant watchdog.
module bus_arbiter_rr #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] m_req_,
    output logic [3:0] m_grnt_,
    output logic [1:0] owner,
    input  logic       bus_rdy_,
    output logic       timeout,
    output logic [1:0] to_master,
    output logic [3:0] mask
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       elig;
    logic [2:0]       p_all, p_oth;
    logic             expire;

    // Returns {found, index}; scan starts after o and visits o last.
    function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] o);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int j = 4; j >= 1; j--) begin
            idx = o + 2'(j);
            if (v[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign elig   = ~m_req_ & ~mask;
    assign p_all  = rr_pick(elig, owner);
    assign p_oth  = rr_pick(elig & ~(4'b0001 << owner), owner);
    assign expire = (cnt == CNT_W'(TIMEOUT - 1)) && bus_rdy_;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            m_grnt_   <= 4'b1111;
            owner     <= 2'd0;
            timeout   <= 1'b0;
            to_master <= 2'd0;
            mask      <= 4'b0000;
            cnt       <= '0;
        end else begin
            timeout <= 1'b0;
            mask    <= mask & ~m_req_;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (p_all[2]) begin
                        m_grnt_ <= ~(4'b0001 << p_all[1:0]);
                        owner   <= p_all[1:0];
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (m_req_[owner]) begin
                        cnt <= '0;
                        if (p_oth[2]) begin
                            m_grnt_ <= ~(4'b0001 << p_oth[1:0]);
                            owner   <= p_oth[1:0];
                        end else begin
                            m_grnt_ <= 4'b1111;
                            state   <= IDLE;
                        end
                    end else if (expire) begin
                        m_grnt_   <= 4'b1111;
                        timeout   <= 1'b1;
                        to_master <= owner;
                        mask      <= (mask & ~m_req_) | (4'b0001 << owner);
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= !bus_rdy_ ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scoreboard bench for bus_arbiter_rr with TIMEOUT=4.
module tb_bus_arbiter_rr;
    logic       clk = 1'b0;
    logic       reset, bus_rdy_, timeout;
    logic [3:0] m_req_, m_grnt_, mask;
    logic [1:0] owner, to_master;
    logic [12:0] qv[$];
    string       qn[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_grnt_(m_grnt_), .owner(owner),
        .bus_rdy_(bus_rdy_), .timeout(timeout), .to_master(to_master), .mask(mask)
    );

    // Expected vector layout: {m_grnt_, owner, timeout, to_master, mask}
    always @(posedge clk) begin
        #1;
        if (qv.size() > 0) begin
            logic [12:0] e;
            string n;
            e = qv.pop_front();
            n = qn.pop_front();
            total++;
            if ({m_grnt_, owner, timeout, to_master, mask} !== e) begin
                bad++;
                $display("FAIL %s: got grnt=%b own=%0d to=%b tm=%0d mask=%b, want grnt=%b own=%0d to=%b tm=%0d mask=%b",
                         n, m_grnt_, owner, timeout, to_master, mask,
                         e[12:9], e[8:7], e[6], e[5:4], e[3:0]);
            end
        end
    end

    task automatic cyc(input string n, input logic r, input logic [3:0] req, input logic rdy,
                       input logic [3:0] g, input logic [1:0] o, input logic t,
                       input logic [1:0] tm, input logic [3:0] mk);
        reset    = r;
        m_req_   = req;
        bus_rdy_ = rdy;
        qv.push_back({g, o, t, tm, mk});
        qn.push_back(n);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; m_req_ = 4'b1111; bus_rdy_ = 1'b1;
        @(negedge clk);
        cyc("reset",     1, 4'b1111, 1, 4'b1111, 0, 0, 0, 4'b0000);
        cyc("req0",      0, 4'b1110, 1, 4'b1110, 0, 0, 0, 4'b0000);
        cyc("rel0",      0, 4'b1111, 1, 4'b1111, 0, 0, 0, 4'b0000);
        cyc("req1",      0, 4'b1101, 0, 4'b1101, 1, 0, 0, 4'b0000);
        cyc("hold1",     0, 4'b0000, 0, 4'b1101, 1, 0, 0, 4'b0000);
        cyc("rr_to2",    0, 4'b0010, 0, 4'b1011, 2, 0, 0, 4'b0000);
        cyc("rr_to3",    0, 4'b0100, 0, 4'b0111, 3, 0, 0, 4'b0000);
        cyc("rr_to0",    0, 4'b1000, 0, 4'b1110, 0, 0, 0, 4'b0000);
        cyc("rr_to1",    0, 4'b0001, 0, 4'b1101, 1, 0, 0, 4'b0000);
        cyc("to2",       0, 4'b0010, 0, 4'b1011, 2, 0, 0, 4'b0000);
        cyc("to3",       0, 4'b0100, 0, 4'b0111, 3, 0, 0, 4'b0000);
        cyc("wrap0",     0, 4'b1010, 0, 4'b1110, 0, 0, 0, 4'b0000);
        cyc("idle",      0, 4'b1111, 1, 4'b1111, 0, 0, 0, 4'b0000);
        cyc("wd_req2",   0, 4'b1011, 1, 4'b1011, 2, 0, 0, 4'b0000);
        cyc("wd_c1",     0, 4'b1011, 1, 4'b1011, 2, 0, 0, 4'b0000);
        cyc("wd_c2",     0, 4'b1011, 1, 4'b1011, 2, 0, 0, 4'b0000);
        cyc("wd_c3",     0, 4'b1011, 1, 4'b1011, 2, 0, 0, 4'b0000);
        cyc("wd_expire", 0, 4'b1011, 1, 4'b1111, 2, 1, 2, 4'b0100);
        cyc("wd_mask1",  0, 4'b1011, 1, 4'b1111, 2, 0, 2, 4'b0100);
        cyc("wd_mask2",  0, 4'b1011, 1, 4'b1111, 2, 0, 2, 4'b0100);
        cyc("unmask",    0, 4'b1111, 1, 4'b1111, 2, 0, 2, 4'b0000);
        cyc("regrant2",  0, 4'b1011, 1, 4'b1011, 2, 0, 2, 4'b0000);
        for (int i = 0; i < 20; i++)
            cyc("alive",  0, 4'b1011, (i % 3) != 2, 4'b1011, 2, 0, 2, 4'b0000);
        cyc("pre_coin",  0, 4'b1011, 1, 4'b1011, 2, 0, 2, 4'b0000);
        cyc("coincide",  0, 4'b1110, 1, 4'b1110, 0, 0, 2, 4'b0000);
        cyc("hand1",     0, 4'b1101, 1, 4'b1101, 1, 0, 2, 4'b0000);
        cyc("wd1_c1",    0, 4'b1101, 1, 4'b1101, 1, 0, 2, 4'b0000);
        cyc("wd1_c2",    0, 4'b1101, 1, 4'b1101, 1, 0, 2, 4'b0000);
        cyc("wd1_c3",    0, 4'b1101, 1, 4'b1101, 1, 0, 2, 4'b0000);
        cyc("wd1_exp",   0, 4'b1101, 1, 4'b1111, 1, 1, 1, 4'b0010);
        cyc("wd1_mask",  0, 4'b1101, 1, 4'b1111, 1, 0, 1, 4'b0010);
        cyc("skip_mask", 0, 4'b1100, 1, 4'b1110, 0, 0, 1, 4'b0010);
        cyc("hold0",     0, 4'b1100, 1, 4'b1110, 0, 0, 1, 4'b0010);
        cyc("mid_reset", 1, 4'b1100, 1, 4'b1111, 0, 0, 0, 4'b0000);
        cyc("post_rst",  0, 4'b1100, 1, 4'b1101, 1, 0, 0, 4'b0000);
        cyc("final_rel", 0, 4'b1111, 1, 4'b1111, 1, 0, 0, 4'b0000);
        #1;
        total++;
        if (qv.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", qv.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
